video_timing_gen: RTL and testbench

//  Generates raster timing (DE, HSYNC, VSYNC) and a built-in RGB test pattern in the pixel clock domain.

---
 rtl/video_timing_gen.sv | 156 +++++++++++++++
 tb/tb_video_timing_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Raster timing generator with a built-in RGB test pattern, running in the
//   pixel clock domain. Its outputs feed the three TMDS channel encoders.
//   Every output comes from one register stage, so DE, the syncs, the colour
//   and the position always describe the same pixel on the same clock.
//
// Ports
//   i_clk          pixel clock
//   i_rst          synchronous, active-high reset
//   i_pattern      00 colour bars, 01 checkerboard, 10 grey ramp, 11 solid
//   i_solid_rgb    {R,G,B} colour used by pattern 11
//   o_de           active-video data enable
//   o_hsync        horizontal sync, active level H_POL
//   o_vsync        vertical sync, active level V_POL
//   o_ctrl         {o_vsync, o_hsync} for the blue-channel encoder
//   o_red/green/blue  pixel colour, zero during blanking
//   o_x, o_y       active position of the current pixel, zero during blanking
//   o_frame_start  one-cycle pulse on the first active pixel of a frame
module video_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_pattern,
  input  logic [23:0] i_solid_rgb,
  output logic        o_de,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic [1:0]  o_ctrl,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_size_check
    $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 4096");
  end

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] BAR_W      = 12'(H_ACTIVE / 8);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic [1:0]  pattern;
  logic [23:0] solid;

  logic        at_origin;
  logic        active;
  logic        hs_on;
  logic        vs_on;
  logic [1:0]  pat_eff;
  logic [23:0] solid_eff;
  logic [11:0] bar;
  logic [23:0] rgb;

  assign at_origin = (h_cnt == 12'd0) && (v_cnt == 12'd0);
  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_on     = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  // v_cnt only moves on the h wrap, so vsync edges always land on h = 0.
  assign vs_on     = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

  // The pattern and solid colour are latched at (0,0); the pixel at (0,0)
  // itself must already use the new selection, so bypass the register there.
  assign pat_eff   = at_origin ? i_pattern   : pattern;
  assign solid_eff = at_origin ? i_solid_rgb : solid;
  assign bar       = h_cnt / BAR_W;

  always_comb begin
    rgb = 24'h000000;
    case (pat_eff)
      2'b00: begin
        case (bar)
          12'd0:   rgb = 24'hFFFFFF;
          12'd1:   rgb = 24'hFFFF00;
          12'd2:   rgb = 24'h00FFFF;
          12'd3:   rgb = 24'h00FF00;
          12'd4:   rgb = 24'hFF00FF;
          12'd5:   rgb = 24'hFF0000;
          12'd6:   rgb = 24'h0000FF;
          default: rgb = 24'h000000;  // bar 7 and any remainder columns
        endcase
      end
      2'b01:   rgb = (h_cnt[3] ^ v_cnt[3]) ? 24'hFFFFFF : 24'h000000;
      2'b10:   rgb = {h_cnt[7:0], h_cnt[7:0], h_cnt[7:0]};
      default: rgb = solid_eff;
    endcase
    if (!active) begin
      rgb = 24'h000000;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt         <= 12'd0;
      v_cnt         <= 12'd0;
      pattern       <= 2'b00;
      solid         <= 24'h000000;
      o_de          <= 1'b0;
      o_hsync       <= ~H_POL;
      o_vsync       <= ~V_POL;
      o_red         <= 8'h00;
      o_green       <= 8'h00;
      o_blue        <= 8'h00;
      o_x           <= 12'd0;
      o_y           <= 12'd0;
      o_frame_start <= 1'b0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= 12'd0;
        v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end

      if (at_origin) begin
        pattern <= i_pattern;
        solid   <= i_solid_rgb;
      end

      o_de          <= active;
      o_hsync       <= hs_on ? H_POL : ~H_POL;
      o_vsync       <= vs_on ? V_POL : ~V_POL;
      o_red         <= rgb[23:16];
      o_green       <= rgb[15:8];
      o_blue        <= rgb[7:0];
      o_x           <= active ? h_cnt : 12'd0;
      o_y           <= active ? v_cnt : 12'd0;
      o_frame_start <= at_origin && active;
    end
  end

  assign o_ctrl = {o_vsync, o_hsync};

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen. Horizontal timing keeps the 640-wide defaults;
// the vertical timing is shortened (12 active lines, FP 2, sync 2, BP 2,
// 18 lines total) so several complete frames fit in a short run.
// Line = 800 clocks, frame = 18 * 800 = 14400 clocks.
module tb_video_timing_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_rgb;
  logic        de, hsync, vsync, frame_start;
  logic [1:0]  ctrl;
  logic [7:0]  red, green, blue;
  logic [11:0] x, y;
  logic [23:0] rgb;

  int checks   = 0;
  int failures = 0;
  int pos      = 0;   // pixel index shown on the outputs since reset release

  localparam int LINE  = 800;
  localparam int FRAME = 14400;

  assign rgb = {red, green, blue};

  always #5 clk = ~clk;

  video_timing_gen #(
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_pattern(pattern_sel), .i_solid_rgb(solid_rgb),
    .o_de(de), .o_hsync(hsync), .o_vsync(vsync), .o_ctrl(ctrl),
    .o_red(red), .o_green(green), .o_blue(blue),
    .o_x(x), .o_y(y), .o_frame_start(frame_start)
  );

  // Advance n clock edges and sample 1 ns after the last one.
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
    pos += n;
  endtask

  task automatic goto_pos(input int target);
    if (target > pos) adv(target - pos);
  endtask

  task automatic test_reset();
    rst = 1'b1; pattern_sel = 2'b00; solid_rgb = 24'h000000;
    adv(5);
    checks++; if (de !== 1'b0) begin failures++; $display("FAIL reset_de: got %b expected 0", de); end
    checks++; if (ctrl !== 2'b11 || hsync !== 1'b1 || vsync !== 1'b1) begin failures++; $display("FAIL reset_sync: got ctrl=%b hs=%b vs=%b expected 11 1 1", ctrl, hsync, vsync); end
    checks++; if (rgb !== 24'h0 || x !== 12'd0 || y !== 12'd0 || frame_start !== 1'b0) begin failures++; $display("FAIL reset_data: got rgb=%h x=%0d y=%0d fs=%b expected 0 0 0 0", rgb, x, y, frame_start); end
    rst = 1'b0;
    adv(1);
    pos = 0;
    checks++; if (de !== 1'b1 || frame_start !== 1'b1) begin failures++; $display("FAIL first_pixel_flags: got de=%b fs=%b expected 1 1", de, frame_start); end
    checks++; if (rgb !== 24'hFFFFFF || x !== 12'd0 || y !== 12'd0) begin failures++; $display("FAIL first_pixel_data: got rgb=%h x=%0d y=%0d expected FFFFFF 0 0", rgb, x, y); end
    adv(1);
    checks++; if (frame_start !== 1'b0 || x !== 12'd1) begin failures++; $display("FAIL second_pixel: got fs=%b x=%0d expected 0 1", frame_start, x); end
  endtask

  task automatic test_line();
    int cnt;
    goto_pos(0);
    cnt = 1;  // already one pixel past the first
    while (de === 1'b1 && cnt < 2000) begin adv(1); cnt++; end
    checks++; if (cnt !== 640) begin failures++; $display("FAIL de_width: got %0d expected 640", cnt); end
    cnt = 0;
    while (hsync === 1'b1 && cnt < 2000) begin adv(1); cnt++; end
    checks++; if (cnt !== 16) begin failures++; $display("FAIL front_porch: got %0d expected 16", cnt); end
    cnt = 0;
    while (hsync === 1'b0 && cnt < 2000) begin adv(1); cnt++; end
    checks++; if (cnt !== 96) begin failures++; $display("FAIL hsync_width: got %0d expected 96", cnt); end
    cnt = 0;
    while (de === 1'b0 && cnt < 2000) begin adv(1); cnt++; end
    checks++; if (cnt !== 48) begin failures++; $display("FAIL back_porch: got %0d expected 48", cnt); end
    checks++; if (x !== 12'd0 || y !== 12'd1 || frame_start !== 1'b0) begin failures++; $display("FAIL line1_start: got x=%0d y=%0d fs=%b expected 0 1 0", x, y, frame_start); end
  endtask

  task automatic test_bars();
    goto_pos(LINE + 0);
    checks++; if (rgb !== 24'hFFFFFF) begin failures++; $display("FAIL bar_x0: got %h expected FFFFFF", rgb); end
    goto_pos(LINE + 79);
    checks++; if (rgb !== 24'hFFFFFF || x !== 12'd79) begin failures++; $display("FAIL bar_x79: got %h x=%0d expected FFFFFF 79", rgb, x); end
    goto_pos(LINE + 80);
    checks++; if (rgb !== 24'hFFFF00) begin failures++; $display("FAIL bar_x80: got %h expected FFFF00", rgb); end
    goto_pos(LINE + 160);
    checks++; if (rgb !== 24'h00FFFF) begin failures++; $display("FAIL bar_x160: got %h expected 00FFFF", rgb); end
    goto_pos(LINE + 480);
    checks++; if (rgb !== 24'h0000FF) begin failures++; $display("FAIL bar_x480: got %h expected 0000FF", rgb); end
    goto_pos(LINE + 560);
    checks++; if (rgb !== 24'h000000 || de !== 1'b1) begin failures++; $display("FAIL bar_x560: got %h de=%b expected 000000 1", rgb, de); end
    goto_pos(LINE + 639);
    checks++; if (rgb !== 24'h000000 || x !== 12'd639) begin failures++; $display("FAIL bar_x639: got %h x=%0d expected 000000 639", rgb, x); end
    goto_pos(LINE + 700);
    checks++; if (rgb !== 24'h0 || x !== 12'd0 || y !== 12'd0 || de !== 1'b0) begin failures++; $display("FAIL blanking: got rgb=%h x=%0d y=%0d de=%b expected 0 0 0 0", rgb, x, y, de); end
  endtask

  task automatic test_vsync();
    int cnt;
    cnt = 0;
    while (vsync === 1'b1 && cnt < 20000) begin adv(1); cnt++; end
    checks++; if (pos !== 14 * LINE) begin failures++; $display("FAIL vsync_start: got pos %0d expected %0d", pos, 14 * LINE); end
    checks++; if (ctrl !== 2'b01) begin failures++; $display("FAIL vsync_ctrl: got %b expected 01", ctrl); end
    cnt = 0;
    while (vsync === 1'b0 && cnt < 20000) begin adv(1); cnt++; end
    checks++; if (cnt !== 2 * LINE) begin failures++; $display("FAIL vsync_width: got %0d expected %0d", cnt, 2 * LINE); end
    cnt = 0;
    while (frame_start !== 1'b1 && cnt < 20000) begin adv(1); cnt++; end
    checks++; if (pos !== FRAME) begin failures++; $display("FAIL frame_period: got %0d expected %0d", pos, FRAME); end
    checks++; if (rgb !== 24'hFFFFFF || x !== 12'd0 || y !== 12'd0 || de !== 1'b1) begin failures++; $display("FAIL frame1_origin: got rgb=%h x=%0d y=%0d de=%b expected FFFFFF 0 0 1", rgb, x, y, de); end
    adv(1);
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL frame_start_width: got %b expected 0", frame_start); end
  endtask

  task automatic test_pattern_switch();
    goto_pos(FRAME + 10 * LINE);
    pattern_sel = 2'b10;
    goto_pos(FRAME + 10 * LINE + 80);
    checks++; if (rgb !== 24'hFFFF00) begin failures++; $display("FAIL switch_midframe: got %h expected FFFF00", rgb); end
    goto_pos(FRAME + 11 * LINE + 5);
    checks++; if (rgb !== 24'hFFFFFF) begin failures++; $display("FAIL switch_lastline: got %h expected FFFFFF", rgb); end
    goto_pos(2 * FRAME + 5);
    checks++; if (rgb !== 24'h050505) begin failures++; $display("FAIL ramp_x5: got %h expected 050505", rgb); end
    goto_pos(2 * FRAME + 256);
    checks++; if (rgb !== 24'h000000) begin failures++; $display("FAIL ramp_x256: got %h expected 000000", rgb); end
    goto_pos(2 * FRAME + 300);
    checks++; if (rgb !== 24'h2C2C2C) begin failures++; $display("FAIL ramp_x300: got %h expected 2C2C2C", rgb); end
    goto_pos(2 * FRAME + 3 * LINE + 255);
    checks++; if (rgb !== 24'hFFFFFF) begin failures++; $display("FAIL ramp_x255: got %h expected FFFFFF", rgb); end
  endtask

  task automatic test_checker_solid();
    pattern_sel = 2'b01;
    goto_pos(3 * FRAME);
    checks++; if (rgb !== 24'h000000) begin failures++; $display("FAIL chk_0_0: got %h expected 000000", rgb); end
    goto_pos(3 * FRAME + 8);
    checks++; if (rgb !== 24'hFFFFFF) begin failures++; $display("FAIL chk_8_0: got %h expected FFFFFF", rgb); end
    goto_pos(3 * FRAME + 8 * LINE);
    checks++; if (rgb !== 24'hFFFFFF) begin failures++; $display("FAIL chk_0_8: got %h expected FFFFFF", rgb); end
    goto_pos(3 * FRAME + 8 * LINE + 8);
    checks++; if (rgb !== 24'h000000) begin failures++; $display("FAIL chk_8_8: got %h expected 000000", rgb); end
    pattern_sel = 2'b11;
    solid_rgb   = 24'h123456;
    goto_pos(4 * FRAME);
    checks++; if (rgb !== 24'h123456) begin failures++; $display("FAIL solid_origin: got %h expected 123456", rgb); end
    goto_pos(4 * FRAME + LINE);
    solid_rgb = 24'hABCDEF;
    goto_pos(4 * FRAME + 2 * LINE + 100);
    checks++; if (rgb !== 24'h123456) begin failures++; $display("FAIL solid_hold: got %h expected 123456", rgb); end
    goto_pos(4 * FRAME + 2 * LINE + 700);
    checks++; if (rgb !== 24'h000000) begin failures++; $display("FAIL solid_blank: got %h expected 000000", rgb); end
  endtask

  task automatic test_midframe_reset();
    goto_pos(4 * FRAME + 5 * LINE + 300);
    checks++; if (de !== 1'b1 || x !== 12'd300 || y !== 12'd5) begin failures++; $display("FAIL pre_reset_pos: got de=%b x=%0d y=%0d expected 1 300 5", de, x, y); end
    rst = 1'b1;
    adv(1);
    checks++; if (de !== 1'b0 || rgb !== 24'h0 || ctrl !== 2'b11) begin failures++; $display("FAIL midreset_out: got de=%b rgb=%h ctrl=%b expected 0 0 11", de, rgb, ctrl); end
    rst = 1'b0;
    pattern_sel = 2'b00;
    adv(1);
    checks++; if (de !== 1'b1 || frame_start !== 1'b1 || x !== 12'd0 || y !== 12'd0) begin failures++; $display("FAIL midreset_restart: got de=%b fs=%b x=%0d y=%0d expected 1 1 0 0", de, frame_start, x, y); end
    checks++; if (rgb !== 24'hFFFFFF) begin failures++; $display("FAIL midreset_rgb: got %h expected FFFFFF", rgb); end
    adv(1);
    checks++; if (x !== 12'd1 || y !== 12'd0 || frame_start !== 1'b0) begin failures++; $display("FAIL midreset_next: got x=%0d y=%0d fs=%b expected 1 0 0", x, y, frame_start); end
  endtask

  initial begin
    test_reset();
    test_line();
    test_bars();
    test_vsync();
    test_pattern_switch();
    test_checker_solid();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
